// File: rtl/dpram_fifo_ctrl.sv
// Single-clock FIFO controller sequencing an external dual-port RAM with a
// registered (1-cycle) read port; owns pointers, occupancy and status flags.
module dpram_fifo_ctrl #(
    parameter int unsigned depth = 4,
    parameter int unsigned width = 16,
    parameter int unsigned size  = 16,
    parameter int unsigned afull = 12
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               wr_req,
    input  logic [width-1:0]   wr_data,
    input  logic               rd_req,
    output logic [width-1:0]   rd_data,
    output logic               rd_valid,
    output logic               full,
    output logic               empty,
    output logic               almost_full,
    output logic [depth:0]     count,
    output logic               overflow,
    output logic               underrun,
    output logic               ram_wen,
    output logic [depth-1:0]   ram_waddr,
    output logic [width-1:0]   ram_wdata,
    output logic [depth-1:0]   ram_raddr,
    input  logic [width-1:0]   ram_rdata
);

    localparam int unsigned CNT_W = depth + 1;
    localparam logic [depth-1:0] PTR_LAST = depth'(size - 1);
    localparam logic [depth:0]   CNT_FULL = CNT_W'(size);
    localparam logic [depth:0]   CNT_AF   = CNT_W'(afull);

    logic [depth-1:0] wr_ptr_q, wr_ptr_d;
    logic [depth-1:0] rd_ptr_q, rd_ptr_d;
    logic [depth:0]   count_q, count_d;
    logic             rd_valid_q, rd_valid_d;
    logic             overflow_q, overflow_d;
    logic             underrun_q, underrun_d;
    logic             flush;
    logic             wa;
    logic             ra;

    assign flush       = reset | clear;
    assign full        = (count_q == CNT_FULL);
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= CNT_AF);

    // Requests in a reset/clear cycle are dropped, including the RAM write strobe.
    assign wa = wr_req & ~full  & ~flush;
    assign ra = rd_req & ~empty & ~flush;

    assign ram_wen   = wa;
    assign ram_waddr = wr_ptr_q;
    assign ram_wdata = wr_data;
    assign ram_raddr = rd_ptr_q;

    assign rd_data  = ram_rdata;
    assign rd_valid = rd_valid_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign underrun = underrun_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_valid_d = ra;
        overflow_d = overflow_q | (wr_req & full);
        underrun_d = underrun_q | (rd_req & empty);
        if (wa) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (ra) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        if (wa && !ra) begin
            count_d = count_q + 1'b1;
        end else if (ra && !wa) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (flush) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            overflow_q <= overflow_d;
            underrun_q <= underrun_d;
        end
    end

endmodule
